// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit engine: state encoding, mode codes,
// and the data-length rule.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    START,
    DATA,
    ADDR,
    PARITY,
    STOP1,
    STOP2
  } txState_t;

  localparam logic [1:0] MODE_UART = 2'b00;
  localparam logic [1:0] MODE_IDLE = 2'b01;
  localparam logic [1:0] MODE_ADDR = 2'b10;

  localparam int GAP_BITS = 11;

  // Frame data length: MAX_W minus the length field, never below 5 bits.
  function automatic int dataLen(input int maxW, input int lenField);
    int len;
    len = maxW - lenField;
    return (len < 5) ? 5 : len;
  endfunction

endpackage

// File: rtl/tx_parity_gen.sv
// Combinational parity bit over the masked data word plus the address bit.
module tx_parity_gen #(
  parameter int MAX_W = 8
) (
  input  logic [MAX_W-1:0] maskedData,
  input  logic             addrBit,
  input  logic             evenPar,
  output logic             parityBit
);

  // Odd parity (evenPar=0) inverts the plain XOR reduction.
  assign parityBit = (^maskedData) ^ addrBit ^ ~evenPar;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: one bit-time per BITCLK cycle, config latched at buffer
// load, optional idle-line gap, address bit, parity and one or two stop bits.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int MAX_W = 8,
  parameter int LEN_W = 2
) (
  input  logic             BITCLK,
  input  logic             reset,
  input  logic             wUCPEN,
  input  logic             wUCPAR,
  input  logic             wUCMSB,
  input  logic             wUCSPB,
  input  logic [LEN_W-1:0] wLEN,
  input  logic [1:0]       wUCMODE,
  input  logic             wUCTXADDR,
  input  logic             wUCTXBRK,
  input  logic [MAX_W-1:0] TxData,
  input  logic             iTXIFG,
  output logic             TxBEN,
  output logic             setTXIFG,
  output logic             clrAUX,
  output logic             setTXCPTIFG,
  output logic             TxBusy,
  output logic             Tx
);

  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int GAP_W = $clog2(GAP_BITS);

  txState_t         stateReg;
  logic             txReg, busyReg, txbenReg, setTxifgReg, clrAuxReg, cptReg;
  logic [MAX_W-1:0] shiftReg;
  logic [CNT_W-1:0] cntReg, lenReg;
  logic [GAP_W-1:0] gapCntReg;
  logic             penReg, spbReg, addrModeReg, addrReg, parReg;

  logic [1:0]       modeNorm;
  logic [CNT_W-1:0] lenLoad, shiftAmt;
  logic [MAX_W-1:0] lenMask, revRaw, maskedData, revData, shiftLoad;
  logic             parityBit, addrLoad, lastStop, loadNow;

  always_comb begin
    modeNorm = (wUCMODE == 2'b11) ? MODE_UART : wUCMODE;
    lenLoad  = CNT_W'(dataLen(MAX_W, int'(wLEN)));
    shiftAmt = CNT_W'(MAX_W) - lenLoad;
  end

  generate
    for (genvar gi = 0; gi < MAX_W; gi++) begin : g_bits
      assign lenMask[gi] = (CNT_W'(gi) < lenLoad);
      assign revRaw[gi]  = TxData[MAX_W-1-gi];
    end
  endgenerate

  // MSB-first frames are bit-reversed within the selected length so the
  // shifter always sends bit 0 next.
  always_comb begin
    maskedData = TxData & lenMask;
    revData    = revRaw >> shiftAmt;
    shiftLoad  = wUCTXBRK ? '0 : (wUCMSB ? revData : maskedData);
    addrLoad   = (modeNorm == MODE_ADDR) & wUCTXADDR & ~wUCTXBRK;
  end

  tx_parity_gen #(.MAX_W(MAX_W)) u_parity (
    .maskedData(maskedData),
    .addrBit   ((modeNorm == MODE_ADDR) & wUCTXADDR),
    .evenPar   (wUCPAR),
    .parityBit (parityBit)
  );

  always_comb begin
    lastStop = (stateReg == STOP2) || (stateReg == STOP1 && !spbReg);
    loadNow  = ((stateReg == IDLE) || lastStop) && !iTXIFG;
  end

  always_ff @(posedge BITCLK) begin
    if (reset) begin
      stateReg    <= IDLE;
      txReg       <= 1'b1;
      busyReg     <= 1'b0;
      txbenReg    <= 1'b0;
      setTxifgReg <= 1'b0;
      clrAuxReg   <= 1'b0;
      cptReg      <= 1'b0;
      shiftReg    <= '0;
      cntReg      <= '0;
      lenReg      <= '0;
      gapCntReg   <= '0;
      penReg      <= 1'b0;
      spbReg      <= 1'b0;
      addrModeReg <= 1'b0;
      addrReg     <= 1'b0;
      parReg      <= 1'b0;
    end else begin
      txbenReg    <= 1'b0;
      setTxifgReg <= 1'b0;
      clrAuxReg   <= 1'b0;
      cptReg      <= 1'b0;
      if (loadNow) begin
        shiftReg    <= shiftLoad;
        lenReg      <= lenLoad;
        cntReg      <= '0;
        gapCntReg   <= '0;
        penReg      <= wUCPEN;
        spbReg      <= wUCSPB;
        addrModeReg <= (modeNorm == MODE_ADDR);
        addrReg     <= addrLoad;
        parReg      <= parityBit & ~wUCTXBRK;
        busyReg     <= 1'b1;
        txbenReg    <= 1'b1;
        setTxifgReg <= 1'b1;
        clrAuxReg   <= 1'b1;
        if (modeNorm == MODE_IDLE && wUCTXADDR) begin
          stateReg <= GAP;
          txReg    <= 1'b1;
        end else begin
          stateReg <= START;
          txReg    <= 1'b0;
        end
      end else if (lastStop) begin
        stateReg <= IDLE;
        txReg    <= 1'b1;
        busyReg  <= 1'b0;
        cptReg   <= 1'b1;
      end else begin
        unique case (stateReg)
          GAP: begin
            if (gapCntReg == GAP_W'(GAP_BITS - 1)) begin
              stateReg <= START;
              txReg    <= 1'b0;
            end else begin
              gapCntReg <= gapCntReg + 1'b1;
            end
          end
          START: begin
            stateReg <= DATA;
            txReg    <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            cntReg   <= '0;
          end
          DATA: begin
            if (cntReg == lenReg - 1'b1) begin
              if (addrModeReg) begin
                stateReg <= ADDR;
                txReg    <= addrReg;
              end else if (penReg) begin
                stateReg <= PARITY;
                txReg    <= parReg;
              end else begin
                stateReg <= STOP1;
                txReg    <= 1'b1;
              end
            end else begin
              txReg    <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              cntReg   <= cntReg + 1'b1;
            end
          end
          ADDR: begin
            if (penReg) begin
              stateReg <= PARITY;
              txReg    <= parReg;
            end else begin
              stateReg <= STOP1;
              txReg    <= 1'b1;
            end
          end
          PARITY: begin
            stateReg <= STOP1;
            txReg    <= 1'b1;
          end
          STOP1: begin
            stateReg <= STOP2;
            txReg    <= 1'b1;
          end
          default: begin
            stateReg <= stateReg;
          end
        endcase
      end
    end
  end

  assign Tx          = txReg;
  assign TxBusy      = busyReg;
  assign TxBEN       = txbenReg;
  assign setTXIFG    = setTxifgReg;
  assign clrAUX      = clrAuxReg;
  assign setTXCPTIFG = cptReg;

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter MAX_W, default 8, giving the widest data field (legal 7..9).
REQ-002 SHALL have parameter LEN_W, default 2, giving the width of wLEN.
REQ-003 Port BITCLK  in  1  bit clock; one bit-time per cycle; all state changes on its rising edge.
REQ-004 Port reset  in  1  reset, synchronous, active-high.
REQ-005 Ports wUCPEN/wUCPAR/wUCMSB/wUCSPB  in  1 each  parity enable / parity select (0 odd, 1 even) / MSB-first / two stop bits.
REQ-006 Port wLEN  in  LEN_W  data length = MAX_W - wLEN bits, minimum 5.
REQ-007 Port wUCMODE  in  2  00 UART, 01 idle-line multiprocessor, 10 address-bit multiprocessor, 11 treated as 00.
REQ-008 Ports wUCTXADDR/wUCTXBRK  in  1 each  address-frame marker / break request.
REQ-009 Port TxData  in  MAX_W  transmit buffer contents.
REQ-010 Port iTXIFG  in  1  0 = buffer holds unsent data.
REQ-011 Ports TxBEN/setTXIFG/clrAUX  out  1 each  one-cycle pulses at buffer load; clrAUX clears wUCTXADDR/wUCTXBRK.
REQ-012 Port setTXCPTIFG  out  1  one-cycle pulse on frame completion with buffer empty.
REQ-013 Ports TxBusy/Tx  out  1 each  frame in progress / serial line, idle high.

Function
REQ-014 States: IDLE, GAP, START, DATA, ADDR, PARITY, STOP1, STOP2.
REQ-015 In IDLE, an edge seeing iTXIFG=0 SHALL load TxData and latch all config, and pulse TxBEN, setTXIFG, clrAUX in the following cycle.
REQ-016 If wUCMODE=01 and wUCTXADDR=1 at load, state SHALL go to GAP and hold Tx=1 for 11 cycles, then START; otherwise START directly.
REQ-017 START SHALL drive Tx=0 registered at the load edge, giving zero-cycle latency from load to start bit.
REQ-018 DATA SHALL shift out exactly the selected length, LSB-first or MSB-first per the latched wUCMSB; bits above the length are ignored.
REQ-019 ADDR (only when wUCMODE=10) SHALL transmit the latched wUCTXADDR.
REQ-020 PARITY (only when wUCPEN=1) SHALL make the count of ones over data plus address bit odd (wUCPAR=0) or even (wUCPAR=1).
REQ-021 STOP1 SHALL drive Tx=1, then STOP2 SHALL drive Tx=1 only if wUCSPB=1.
REQ-022 If wUCTXBRK=1 at load, every DATA/ADDR/PARITY slot SHALL be 0 and TxData is ignored; stop bits are unchanged.
REQ-023 TxBusy SHALL be 1 from the load edge through the final stop bit, including GAP.
REQ-024 At the last stop bit, iTXIFG=0 SHALL reload and begin START the next cycle with no idle bit, and setTXCPTIFG SHALL stay 0.
REQ-025 At the last stop bit, iTXIFG=1 SHALL return the state to IDLE with Tx=1 and pulse setTXCPTIFG one cycle.
REQ-026 Config changes mid-frame SHALL NOT affect the current frame.
REQ-027 iTXIFG=0 mid-frame SHALL only be sampled at the last stop bit.

Reset
REQ-028 On reset, the next edge SHALL set state=IDLE, Tx=1, TxBusy=0, all pulses 0, and clear counters and the shift register; this applies mid-frame too.
REQ-029 With reset held, iTXIFG SHALL be ignored.

Structure
REQ-030 Package uart_tx_pkg SHALL hold the state encoding, mode constants (MODE_UART, MODE_IDLE, MODE_ADDR) and GAP_BITS=11.
REQ-031 The bit counter SHALL be $clog2(MAX_W+1) wide.
REQ-032 Sub-module tx_parity_gen SHALL compute parity from masked data, address bit and wUCPAR combinationally.

Verification
REQ-033 8N1 LSB, TxData=A5 -> Tx=0,1,0,1,0,0,1,0,1,1; setTXCPTIFG pulses after the stop bit.
REQ-034 7-bit, odd parity, 2 stop, MSB, TxData=35 -> Tx=0,0,1,1,0,1,0,1,1,1,1 (11 bits).
REQ-035 Mode 10, 8-bit, even parity, addr=1, TxData=0F, LSB -> Tx=0,1,1,1,1,0,0,0,0,1,1,1; clrAUX pulses once.
REQ-036 Break, 8N1, TxData=FF -> Tx=0 for 9 cycles then 1; mode 01 with addr=1 -> 11 cycles Tx=1 before the start bit.
REQ-037 iTXIFG=0 during the stop bit of 55 -> next start bit on the following cycle, no setTXCPTIFG; reset at bit 4 -> Tx=1, TxBusy=0 next edge.
